ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register's operand and ALU-op outputs. It accepts one M-extension operation at a time and holds the pipeline via `stall_o` while computing. It returns a 32-bit result with a one-cycle `done` pulse, which the EX result mux selects in place of the ALU output.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: valid M-op in EX; already qualified by the decoder and not flushed.
- `op` input 3: funct3 code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1` input 32: forwarded operand A (dividend / multiplicand).
- `rs2` input 32: forwarded operand B (divisor / multiplier).
- `flush` input 1: kill the in-flight operation.
- `stall_o` output 1: freezes PC, IF/ID and ID/EX.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse; `result` is valid.
- `result` output 32: registered result; holds its value until the next completion.

## Operation
- States: IDLE, CALC, FIN.
- IDLE:
  - `start=1` accepts the operands.
  - Special cases (below) go to FIN.
  - Otherwise go to CALC with `cnt=0`.
  - `start` is ignored in CALC and FIN.
- Operand prep on accept:
  - Compute magnitudes per signedness (MULHSU: rs1 signed, rs2 unsigned; DIV/REM signed).
  - Latch the result sign: quotient/product sign is the XOR of the operand signs; remainder sign is the dividend sign.
- CALC, multiply: shift-add, one multiplier bit per cycle into a 64-bit accumulator.
- CALC, divide: restoring division, one quotient bit per cycle using a 33-bit partial remainder.
- CALC exits to FIN on the edge where `cnt==31`. This is exactly 32 cycles.
- FIN:
  - `result` is the sign-corrected selection: MUL gives low 32 bits, MULH* gives high 32 bits, DIV* gives the quotient, REM* gives the remainder.
  - `result` is written on the edge entering FIN.
  - `done=1` for one cycle.
  - Next state is IDLE.
- Special cases (no iteration; result registered on the accept edge):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- `stall_o = (IDLE & start & ~flush) | CALC`.
  - `stall_o` is low in FIN, so the instruction leaves EX with `result` at the end of FIN.
- `flush` in any state: next state is IDLE, `done` stays 0, `result` is unchanged. `flush` takes priority over `start` and over CALC→FIN.

## Timing
- Reset values: state IDLE, `cnt=0`, `result=0`, `done=0`, `busy=0`, `stall_o=0`. Internal accumulators are cleared.
- Accept in cycle 0, normal path:
  - CALC in cycles 1–32.
  - FIN/`done` in cycle 33.
  - IDLE in cycle 34.
  - `stall_o` high in cycles 0–32.
- Special-case path: `done` in cycle 1; `stall_o` high only in cycle 0.
- Back-to-back M-ops: the second `start` is accepted in the cycle after FIN. There is no bubble beyond FIN.
- Reset mid-CALC: immediate return to reset values. No `done` is generated.
- `busy` is high in CALC and FIN.

## Configuration
- Macro `MULDIV_FAST_MUL_EN`.
- When defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 33×33 signed multiply on the accept edge and go straight to FIN, so `done` arrives in cycle 1.
  - Divides are unchanged.
- When undefined: all multiplies use the 32-cycle iterative path with 33-cycle latency.

## Structure
- Shared package `muldiv_pkg`:
  - `muldiv_op_e` enum (the 8 funct3 codes).
  - `muldiv_state_e` enum (IDLE/CALC/FIN).
  - Constants `MULDIV_ITER=32`, `DIV0_QUOT=32'hFFFF_FFFF`, `INT_MIN=32'h8000_0000`.
- One sub-module, `muldiv_step`: a combinational single iteration.
  - Multiply mode: conditional add plus shift.
  - Divide mode: trial subtract and quotient-bit select.
  - Instantiated once inside `ex_muldiv`.

## Test plan
- DIV, rs1=-20 (0xFFFFFFEC), rs2=3 → `done` in cycle 33, `result`=0xFFFFFFFA (-6); REM with the same operands → 0xFFFFFFFE (-2).
- DIVU, rs2=0 → `done` in cycle 1, `result`=0xFFFFFFFF; REMU rs1=0x1234 → 0x1234.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF → 0x80000000 in cycle 1; REM → 0.
- MULH rs1=0x80000000, rs2=0x80000000 → 0x40000000. MULHSU rs1=-1, rs2=0xFFFFFFFF → 0xFFFFFFFF. Latency is 33 without `MULDIV_FAST_MUL_EN` and 1 with it.
- `flush` asserted in CALC cycle 10 → IDLE next cycle, `stall_o` low, no `done` pulse, previous `result` retained. Then a MUL 7×6 → 42.
- `rst` low in CALC cycle 5 → all outputs at reset values immediately. After release, DIVU 100/7 → 14.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } muldiv_state_e;

  localparam int          MULDIV_ITER = 32;
  localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;

  function automatic logic [31:0] cond_neg32(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div_mode,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] prem;
  logic          ge;

  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    // 33-bit partial remainder: previous remainder with next dividend bit shifted in
    prem = {hi, lo[XLEN-1]};
    ge   = prem >= {1'b0, opb};
    if (div_mode) begin
      hi_nxt = ge ? (prem[XLEN-1:0] - opb) : prem[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], ge};
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M multiply/divide unit, 32-cycle iterative core with stall/done handshake.
// Optional MULDIV_FAST_MUL_EN: single-cycle 33x33 multiply for all MUL* ops.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall_o,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [4:0] CNT_LAST = 5'(MULDIV_ITER - 1);

  muldiv_state_e   state, state_nxt;
  logic [4:0]      cnt;
  muldiv_op_e      op_q;
  logic            neg_q;
  logic [XLEN-1:0] acc_hi, acc_lo, opb;
  logic [XLEN-1:0] step_hi, step_lo;

  muldiv_op_e      op_in;
  logic            a_sgn, b_sgn, a_neg, b_neg, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div0, ovf, special;
  logic [XLEN-1:0] special_res;
  logic            fast_take;
  logic [XLEN-1:0] fast_res;
  logic            accept;

  function automatic logic [31:0] finalize(input muldiv_op_e o, input logic neg,
                                           input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] prod;
    prod = {hi, lo};
    if (neg) prod = ~prod + 64'd1;
    case (o)
      OP_MUL:                       return prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return prod[63:32];
      OP_DIV, OP_DIVU:              return cond_neg32(lo, neg);
      default:                      return cond_neg32(hi, neg);
    endcase
  endfunction

  // Operand preparation on accept
  always_comb begin
    op_in = muldiv_op_e'(op);
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op_in)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      OP_MULHSU:                       a_sgn = 1'b1;
      default: ;
    endcase
    a_neg  = a_sgn & rs1[XLEN-1];
    b_neg  = b_sgn & rs2[XLEN-1];
    a_mag  = cond_neg32(rs1, a_neg);
    b_mag  = cond_neg32(rs2, b_neg);
    // Remainder follows the dividend sign; quotient/product the XOR of both
    neg_in = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);

    div0 = op[2] & (rs2 == '0);
    ovf  = (op_in == OP_DIV || op_in == OP_REM) && (rs1 == INT_MIN) && (rs2 == '1);
    special = div0 | ovf;
    if (div0)
      special_res = op[1] ? rs1 : DIV0_QUOT;
    else
      special_res = op[1] ? '0 : INT_MIN;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN+1:0] fast_prod;
  logic                     unused_fast;

  always_comb begin
    fast_a    = {a_neg, rs1};
    fast_b    = {b_neg, rs2};
    fast_prod = fast_a * fast_b;
    fast_take = ~op[2];
    fast_res  = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
  assign unused_fast = ^fast_prod[2*XLEN+1:2*XLEN];
`else
  assign fast_take = 1'b0;
  assign fast_res  = '0;
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_mode (op_q[2]),
    .hi       (acc_hi),
    .lo       (acc_lo),
    .opb      (opb),
    .hi_nxt   (step_hi),
    .lo_nxt   (step_lo)
  );

  assign accept = (state == IDLE) & start & ~flush;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (special | fast_take) ? FIN : CALC;
      CALC: begin
        if (flush)                state_nxt = IDLE;
        else if (cnt == CNT_LAST) state_nxt = FIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign done    = (state == FIN) & ~flush;
  assign stall_o = accept | (state == CALC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      op_q   <= OP_MUL;
      neg_q  <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= op_in;
            neg_q <= neg_in;
            cnt   <= '0;
            if (special) begin
              result <= special_res;
            end else if (fast_take) begin
              result <= fast_res;
            end else begin
              // Multiply: lo = multiplier, opb = multiplicand. Divide: lo = dividend, opb = divisor.
              acc_hi <= '0;
              acc_lo <= op[2] ? a_mag : b_mag;
              opb    <= op[2] ? b_mag : a_mag;
            end
          end
        end
        CALC: begin
          if (!flush) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 5'd1;
            if (cnt == CNT_LAST)
              result <= finalize(op_q, neg_q, step_hi, step_lo);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv (latency, special cases, flush, async reset).
module tb_ex_muldiv;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        stall_o, busy, done;
  logic [31:0] result;

  int n_total = 0;
  int n_pass  = 0;

  int          lat;
  logic [31:0] res;
  logic        st0, std;
  int          dcnt;

  ex_muldiv dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1     (rs1),
    .rs2     (rs2),
    .flush   (flush),
    .stall_o (stall_o),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Issue one op at cycle 0 and wait (bounded) for done; latency counts cycles after accept.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int l, output logic [31:0] r, output logic s0, output logic sd);
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    #1 s0 = stall_o;
    @(negedge clk);
    start = 1'b0;
    l = 1;
    while (done !== 1'b1 && l < 100) begin
      @(negedge clk);
      l++;
    end
    r  = result;
    sd = stall_o;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 3'd0; rs1 = '0; rs2 = '0; flush = 1'b0;
    #12;
    check("reset_result", result, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_stall", {31'b0, stall_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    run_op(3'd4, 32'hFFFF_FFEC, 32'd3, lat, res, st0, std);
    check("div_lat", lat, 33);
    check("div_res", res, 32'hFFFF_FFFA);
    check("div_stall_c0", {31'b0, st0}, 32'h1);
    check("div_stall_fin", {31'b0, std}, 32'h0);
    check("div_busy_fin", {31'b0, busy}, 32'h1);

    run_op(3'd6, 32'hFFFF_FFEC, 32'd3, lat, res, st0, std);
    check("rem_lat", lat, 33);
    check("rem_res", res, 32'hFFFF_FFFE);

    run_op(3'd5, 32'd55, 32'd0, lat, res, st0, std);
    check("divu0_lat", lat, 1);
    check("divu0_res", res, 32'hFFFF_FFFF);
    check("divu0_stall_c0", {31'b0, st0}, 32'h1);
    check("divu0_stall_fin", {31'b0, std}, 32'h0);

    run_op(3'd7, 32'h0000_1234, 32'd0, lat, res, st0, std);
    check("remu0_lat", lat, 1);
    check("remu0_res", res, 32'h0000_1234);

    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, st0, std);
    check("div_ovf_lat", lat, 1);
    check("div_ovf_res", res, 32'h8000_0000);

    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, st0, std);
    check("rem_ovf_lat", lat, 1);
    check("rem_ovf_res", res, 32'h0);

    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, lat, res, st0, std);
    check("mulh_lat", lat, MUL_LAT);
    check("mulh_res", res, 32'h4000_0000);

    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, st0, std);
    check("mulhsu_lat", lat, MUL_LAT);
    check("mulhsu_res", res, 32'hFFFF_FFFF);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, lat, res, st0, std);
    check("mul_neg_res", res, 32'hFFFF_FFF1);

    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, st0, std);
    check("mulhu_res", res, 32'hFFFF_FFFE);

    // Flush during CALC cycle 10 of a divide
    @(negedge clk);
    op = 3'd5; rs1 = 32'd1000; rs2 = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_pre_stall", {31'b0, stall_o}, 32'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy", {31'b0, busy}, 32'h0);
    check("flush_stall", {31'b0, stall_o}, 32'h0);
    check("flush_result_kept", result, 32'hFFFF_FFFE);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    check("flush_no_done", dcnt, 0);
    check("flush_result_still", result, 32'hFFFF_FFFE);

    run_op(3'd0, 32'd7, 32'd6, lat, res, st0, std);
    check("mul_7x6_lat", lat, MUL_LAT);
    check("mul_7x6_res", res, 32'd42);

    // Asynchronous reset in CALC cycle 5
    @(negedge clk);
    op = 3'd5; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_result", result, 32'h0);
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_done", {31'b0, done}, 32'h0);
    check("rst_mid_stall", {31'b0, stall_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    run_op(3'd5, 32'd100, 32'd7, lat, res, st0, std);
    check("divu_post_rst_lat", lat, 33);
    check("divu_post_rst_res", res, 32'd14);
    @(negedge clk);
    check("idle_after_fin_busy", {31'b0, busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
